// File: rtl/effect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : effect_ctrl_pkg
//  Description : Shared step-law types, tier constants and tier lookup for
//                the effect parameter controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package effect_ctrl_pkg;

    typedef enum logic {
        STEP_LINEAR = 1'b0,
        STEP_TIERED = 1'b1
    } step_law_e;

    localparam logic [31:0] TIER_BOUND0 = 32'd100;
    localparam logic [31:0] TIER_BOUND1 = 32'd500;
    localparam logic [31:0] TIER_BOUND2 = 32'd1000;
    localparam logic [31:0] TIER_STEP0  = 32'd10;
    localparam logic [31:0] TIER_STEP1  = 32'd50;
    localparam logic [31:0] TIER_STEP2  = 32'd100;
    localparam logic [31:0] TIER_STEP3  = 32'd500;

    // Decrement looks up tier(v-1) so that inc/dec are inverse on grid points.
    function automatic logic [31:0] tier_step(input logic [31:0] x);
        if (x < TIER_BOUND0)      return TIER_STEP0;
        else if (x < TIER_BOUND1) return TIER_STEP1;
        else if (x < TIER_BOUND2) return TIER_STEP2;
        else                      return TIER_STEP3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : key_debouncer
//  Description : Active-low key synchroniser, debouncer and auto-repeat FSM
//                producing single-cycle step pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    input  logic i_cancel,
    output logic o_step
);

    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_RP_W   = $clog2(c_RP_MAX + 1);

    localparam logic [c_DB_W-1:0] c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_RP_W-1:0] c_DELAY_LAST = c_RP_W'(REPEAT_DELAY - 1);
    localparam logic [c_RP_W-1:0] c_RATE_LAST  = c_RP_W'(REPEAT_RATE - 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_HELD_WAIT = 2'd1;
    localparam logic [1:0] c_REPEATING = 2'd2;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_pressed;
    logic              r_pressed_d;
    logic              r_step;
    logic [c_DB_W-1:0] r_db_cnt;
    logic [c_RP_W-1:0] r_rp_cnt;
    logic [1:0]        r_state;
    logic              w_sync_pressed;

    assign w_sync_pressed = ~r_sync2;
    assign o_step         = r_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_pressed   <= 1'b0;
            r_pressed_d <= 1'b0;
            r_step      <= 1'b0;
            r_db_cnt    <= '0;
            r_rp_cnt    <= '0;
            r_state     <= c_IDLE;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;

            if (w_sync_pressed != r_pressed) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_pressed <= w_sync_pressed;
                    r_db_cnt  <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
            r_pressed_d <= r_pressed;

            // A cancelled hold parks in IDLE; only a fresh press edge restarts it.
            r_step <= 1'b0;
            if (i_cancel || !r_pressed) begin
                r_state  <= c_IDLE;
                r_rp_cnt <= '0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (!r_pressed_d) begin
                            r_step   <= 1'b1;
                            r_rp_cnt <= '0;
                            r_state  <= c_HELD_WAIT;
                        end
                    end
                    c_HELD_WAIT: begin
                        if (r_rp_cnt == c_DELAY_LAST) begin
                            r_step   <= 1'b1;
                            r_rp_cnt <= '0;
                            r_state  <= c_REPEATING;
                        end else begin
                            r_rp_cnt <= r_rp_cnt + c_RP_W'(1);
                        end
                    end
                    c_REPEATING: begin
                        if (r_rp_cnt == c_RATE_LAST) begin
                            r_step   <= 1'b1;
                            r_rp_cnt <= '0;
                        end else begin
                            r_rp_cnt <= r_rp_cnt + c_RP_W'(1);
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/effect_param_controller.sv
`default_nettype none
// ============================================================================
//  Module      : effect_param_controller
//  Description : Front-panel controller stepping NUM_PARAMS clamped effect
//                parameters from two debounced, auto-repeating keys.
//  Revision    : 1.0 - initial release
// ============================================================================
module effect_param_controller
    import effect_ctrl_pkg::*;
#(
    parameter int                             NUM_PARAMS      = 2,
    parameter int                             PARAM_W         = 16,
    parameter int                             SEL_W           = 10,
    parameter logic [NUM_PARAMS*PARAM_W-1:0]  P_MIN           = {16'd20, 16'd1},
    parameter logic [NUM_PARAMS*PARAM_W-1:0]  P_MAX           = {16'd32000, 16'd50},
    parameter logic [NUM_PARAMS*PARAM_W-1:0]  P_DEFAULT       = {16'd1000, 16'd1},
    parameter logic [NUM_PARAMS-1:0]          P_TIERED        = 2'b10,
    parameter int                             DEBOUNCE_CYCLES = 500000,
    parameter int                             REPEAT_DELAY    = 25000000,
    parameter int                             REPEAT_RATE     = 5000000
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic                            key_dec_n,
    input  logic                            key_inc_n,
    input  logic [SEL_W-1:0]                SW,
    output logic [NUM_PARAMS*PARAM_W-1:0]   values,
    output logic [3:0]                      mode,
    output logic                            changed
);

    localparam logic [SEL_W-1:0] c_SEL_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] c_SEL_LAST = SEL_W'(NUM_PARAMS);

    logic [SEL_W-1:0]   r_sw_sync1;
    logic [SEL_W-1:0]   r_sw_sync2;
    logic [3:0]         r_mode;
    logic [3:0]         w_mode_next;
    logic               r_changed;
    logic [PARAM_W-1:0] r_val [NUM_PARAMS];
    logic               w_cancel;
    logic               w_inc_ev;
    logic               w_dec_ev;
    logic [PARAM_W-1:0] w_cur;
    logic [PARAM_W-1:0] w_min;
    logic [PARAM_W-1:0] w_max;
    logic [PARAM_W-1:0] w_new;
    step_law_e          w_law;
    logic [PARAM_W:0]   w_ext;
    logic [PARAM_W:0]   w_step;
    logic [PARAM_W:0]   w_sum;
    logic               w_under;
    logic               w_apply;

    always_comb begin
        w_mode_next = 4'd0;
        if (r_sw_sync2 >= c_SEL_ONE && r_sw_sync2 <= c_SEL_LAST)
            w_mode_next = r_sw_sync2[3:0];
    end

    assign w_cancel = (w_mode_next != r_mode);

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
    ) u_inc_key (
        .clk      (CLK),
        .rst      (reset),
        .i_key_n  (key_inc_n),
        .i_cancel (w_cancel),
        .o_step   (w_inc_ev)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
    ) u_dec_key (
        .clk      (CLK),
        .rst      (reset),
        .i_key_n  (key_dec_n),
        .i_cancel (w_cancel),
        .o_step   (w_dec_ev)
    );

    // Widened arithmetic: underflow is flagged explicitly, overflow cannot occur.
    always_comb begin
        w_cur = '0;
        w_min = '0;
        w_max = '0;
        w_law = STEP_LINEAR;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            if (r_mode == 4'(i + 1)) begin
                w_cur = r_val[i];
                w_min = P_MIN[i*PARAM_W +: PARAM_W];
                w_max = P_MAX[i*PARAM_W +: PARAM_W];
                w_law = P_TIERED[i] ? STEP_TIERED : STEP_LINEAR;
            end
        end
        w_ext = {1'b0, w_cur};
        if (w_law == STEP_TIERED)
            w_step = (PARAM_W+1)'(tier_step(w_inc_ev ? 32'(w_cur) : 32'(w_cur) - 32'd1));
        else
            w_step = (PARAM_W+1)'(1);
        w_under = 1'b0;
        if (w_inc_ev) begin
            w_sum = w_ext + w_step;
        end else begin
            w_under = (w_step > w_ext);
            w_sum   = w_ext - w_step;
        end
        if (w_under || w_sum < {1'b0, w_min})
            w_new = w_min;
        else if (w_sum > {1'b0, w_max})
            w_new = w_max;
        else
            w_new = w_sum[PARAM_W-1:0];
        w_apply = (w_inc_ev ^ w_dec_ev) && (r_mode != 4'd0) && (w_new != w_cur);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_sw_sync1 <= '0;
            r_sw_sync2 <= '0;
            r_mode     <= 4'd0;
            r_changed  <= 1'b0;
            for (int i = 0; i < NUM_PARAMS; i++)
                r_val[i] <= P_DEFAULT[i*PARAM_W +: PARAM_W];
        end else begin
            r_sw_sync1 <= SW;
            r_sw_sync2 <= r_sw_sync1;
            r_mode     <= w_mode_next;
            r_changed  <= w_apply;
            for (int i = 0; i < NUM_PARAMS; i++)
                if (w_apply && r_mode == 4'(i + 1))
                    r_val[i] <= w_new;
        end
    end

    for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_values
        assign values[g*PARAM_W +: PARAM_W] = r_val[g];
    end

    assign mode    = r_mode;
    assign changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_effect_param_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_effect_param_controller
//  Description : Directed self-checking bench for effect_param_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_effect_param_controller;

    logic        CLK;
    logic        reset;
    logic        key_dec_n;
    logic        key_inc_n;
    logic [9:0]  SW;
    logic [31:0] values;
    logic [3:0]  mode;
    logic        changed;

    int n_checks = 0;
    int n_errors = 0;
    int chg_cnt  = 0;
    int c0;

    typedef struct {
        logic [9:0]  sw;
        bit          inc;
        logic [3:0]  mode;
        logic [15:0] p0;
        logic [15:0] p1;
        int          chg;
    } vec_t;

    vec_t vq[$];

    effect_param_controller #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (5)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .key_dec_n (key_dec_n),
        .key_inc_n (key_inc_n),
        .SW        (SW),
        .values    (values),
        .mode      (mode),
        .changed   (changed)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) if (changed === 1'b1) chg_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic press(input bit inc, input bit dec, input int hold);
        key_inc_n = ~inc;
        key_dec_n = ~dec;
        tick(hold);
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        tick(12);
    endtask

    task automatic add(input int sw, input bit inc, input int md, input int p0, input int p1, input int chg);
        vec_t v;
        v.sw = 10'(sw); v.inc = inc; v.mode = 4'(md);
        v.p0 = 16'(p0); v.p1 = 16'(p1); v.chg = chg;
        vq.push_back(v);
    endtask

    initial begin
        // Table starts from p0=3, p1=1000 (after the single-press and bounce sequences)
        add(2, 1, 2, 3, 1500, 1);
        add(2, 0, 2, 3, 1000, 1);  add(2, 0, 2, 3, 900, 1);  add(2, 0, 2, 3, 800, 1);
        add(2, 0, 2, 3, 700, 1);   add(2, 0, 2, 3, 600, 1);  add(2, 0, 2, 3, 500, 1);
        add(2, 0, 2, 3, 450, 1);   add(2, 0, 2, 3, 400, 1);  add(2, 0, 2, 3, 350, 1);
        add(2, 0, 2, 3, 300, 1);   add(2, 0, 2, 3, 250, 1);  add(2, 0, 2, 3, 200, 1);
        add(2, 0, 2, 3, 150, 1);   add(2, 0, 2, 3, 100, 1);  add(2, 0, 2, 3, 90, 1);
        add(2, 1, 2, 3, 100, 1);
        add(2, 0, 2, 3, 90, 1);    add(2, 0, 2, 3, 80, 1);   add(2, 0, 2, 3, 70, 1);
        add(2, 0, 2, 3, 60, 1);    add(2, 0, 2, 3, 50, 1);   add(2, 0, 2, 3, 40, 1);
        add(2, 0, 2, 3, 30, 1);    add(2, 0, 2, 3, 20, 1);
        add(2, 0, 2, 3, 20, 0);
        add(7, 1, 0, 3, 20, 0);
        add(1, 0, 1, 2, 20, 1);    add(1, 0, 1, 1, 20, 1);   add(1, 0, 1, 1, 20, 0);
        add(1, 1, 1, 2, 20, 1);

        reset = 1'b1; key_inc_n = 1'b1; key_dec_n = 1'b1; SW = '0;
        tick(3);
        check("reset_p0", 32'(values[15:0]), 1);
        check("reset_p1", 32'(values[31:16]), 1000);
        check("reset_mode", 32'(mode), 0);
        check("reset_changed", 32'(changed), 0);
        reset = 1'b0;
        tick(2);

        // Single clean press: value visible exactly 8 cycles after the falling edge
        SW = 10'd1;
        tick(5);
        check("sel_mode1", 32'(mode), 1);
        check("pre_press_p0", 32'(values[15:0]), 1);
        c0 = chg_cnt;
        key_inc_n = 1'b0;
        tick(7);
        check("latency_7", 32'(values[15:0]), 1);
        tick(1);
        check("latency_8", 32'(values[15:0]), 2);
        check("changed_hi", 32'(changed), 1);
        tick(1);
        check("changed_lo", 32'(changed), 0);
        key_inc_n = 1'b1;
        tick(12);
        check("press_chg_count", chg_cnt - c0, 1);

        // Bounce: 2-cycle toggles never satisfy the debouncer
        c0 = chg_cnt;
        for (int i = 0; i < 6; i++) begin
            key_inc_n = 1'(i % 2);
            tick(2);
        end
        key_inc_n = 1'b0;
        tick(15);
        key_inc_n = 1'b1;
        tick(12);
        check("bounce_p0", 32'(values[15:0]), 3);
        check("bounce_chg", chg_cnt - c0, 1);

        foreach (vq[i]) begin
            SW = vq[i].sw;
            tick(5);
            check($sformatf("vec%0d_mode", i), 32'(mode), 32'(vq[i].mode));
            c0 = chg_cnt;
            press(vq[i].inc, ~vq[i].inc, 10);
            check($sformatf("vec%0d_p0", i), 32'(values[15:0]), 32'(vq[i].p0));
            check($sformatf("vec%0d_p1", i), 32'(values[31:16]), 32'(vq[i].p1));
            check($sformatf("vec%0d_chg", i), chg_cnt - c0, vq[i].chg);
        end

        // Simultaneous inc and dec
        c0 = chg_cnt;
        press(1'b1, 1'b1, 10);
        check("both_p0", 32'(values[15:0]), 2);
        check("both_p1", 32'(values[31:16]), 20);
        check("both_chg", chg_cnt - c0, 0);

        // Saturation at P_MAX of parameter 0
        press(1'b1, 1'b0, 300);
        check("sat_reach_p0", 32'(values[15:0]), 50);
        c0 = chg_cnt;
        press(1'b1, 1'b0, 60);
        check("sat_hold_p0", 32'(values[15:0]), 50);
        check("sat_hold_chg", chg_cnt - c0, 0);
        press(1'b0, 1'b1, 300);
        check("sat_min_p0", 32'(values[15:0]), 1);

        // Auto-repeat: events at press, +20, +25, +30, +35
        c0 = chg_cnt;
        key_inc_n = 1'b0;
        tick(8);
        check("rep_first", 32'(values[15:0]), 2);
        tick(19);
        check("rep_before_delay", 32'(values[15:0]), 2);
        tick(1);
        check("rep_after_delay", 32'(values[15:0]), 3);
        tick(12);
        key_inc_n = 1'b1;
        tick(10);
        check("rep_final", 32'(values[15:0]), 6);
        tick(40);
        check("rep_stopped", 32'(values[15:0]), 6);
        check("rep_chg", chg_cnt - c0, 5);

        // SW 2->1 mid-hold cancels repeats until a fresh press
        SW = 10'd2;
        tick(5);
        check("mid_mode2", 32'(mode), 2);
        key_inc_n = 1'b0;
        tick(34);
        SW = 10'd1;
        tick(46);
        check("mid_p1", 32'(values[31:16]), 50);
        check("mid_p0_untouched", 32'(values[15:0]), 6);
        check("mid_mode1", 32'(mode), 1);
        key_inc_n = 1'b1;
        tick(12);
        check("mid_after_release", 32'(values[15:0]), 6);
        press(1'b1, 1'b0, 10);
        check("mid_new_press", 32'(values[15:0]), 7);

        // Reset during repeat, key still held through and after reset
        key_inc_n = 1'b0;
        tick(30);
        check("prereset_p0", 32'(values[15:0]), 9);
        reset = 1'b1;
        tick(1);
        check("midrst_p0", 32'(values[15:0]), 1);
        check("midrst_p1", 32'(values[31:16]), 1000);
        check("midrst_mode", 32'(mode), 0);
        tick(1);
        reset = 1'b0;
        tick(12);
        check("rehold_p0", 32'(values[15:0]), 2);
        check("rehold_mode", 32'(mode), 1);
        key_inc_n = 1'b1;
        tick(12);
        check("rehold_release", 32'(values[15:0]), 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
